// File: rtl/delta_pkg.sv
// Shared constants and arithmetic helpers for the adaptive delta demodulator.
// Saturating integrator math and the CVSD-style step adaptation rule.
package delta_pkg;

  localparam int WIDTH_D    = 8;
  localparam int STEP_MIN_D = 1;
  localparam int STEP_MAX_D = 16;
  localparam int RUN_LEN_D  = 3;
  localparam int AVG_LOG2_D = 2;
  localparam int STEP_W     = $clog2(STEP_MAX_D) + 1;

  function automatic int unsigned sat_add(
    input int unsigned a,
    input int unsigned b,
    input int unsigned lim
  );
    int unsigned s;
    s = a + b;
    return (s > lim) ? lim : s;
  endfunction

  function automatic int unsigned sat_sub(
    input int unsigned a,
    input int unsigned b
  );
    return (b > a) ? 0 : a - b;
  endfunction

  function automatic int unsigned step_adapt(
    input int unsigned step,
    input int unsigned run,
    input int unsigned run_len,
    input logic        bit_i,
    input logic        last_bit,
    input logic        en,
    input int unsigned smin,
    input int unsigned smax
  );
    int unsigned r;
    r = step;
    if (!en) begin
      r = smin;
    end else if (run == run_len) begin
      r = (2 * step > smax) ? smax : 2 * step;
    end else if (bit_i != last_bit) begin
      r = (step / 2 < smin) ? smin : step / 2;
    end
    return r;
  endfunction

endpackage

// File: rtl/moving_avg.sv
// Power-of-two moving average over the reconstructed samples.
// Ring buffer with running sum; output registered one cycle after input.
module moving_avg
  import delta_pkg::*;
#(
  parameter int WIDTH    = WIDTH_D,
  parameter int AVG_LOG2 = AVG_LOG2_D
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_filt,
  output logic             o_valid
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = WIDTH + AVG_LOG2;

  logic [WIDTH-1:0]    r_buf [DEPTH];
  logic [AVG_LOG2-1:0] r_ptr;
  logic [SW-1:0]       r_sum;
  logic [WIDTH-1:0]    r_filt;
  logic                r_valid;

  logic [WIDTH-1:0] w_old;
  logic [SW-1:0]    w_sum_nxt;

  assign w_old     = r_buf[r_ptr];
  assign w_sum_nxt = r_sum + SW'(i_data) - SW'(w_old);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_ptr   <= '0;
      r_sum   <= '0;
      r_filt  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_buf[r_ptr] <= i_data;
        r_ptr        <= r_ptr + 1'b1;
        r_sum        <= w_sum_nxt;
        r_filt       <= w_sum_nxt[SW-1:AVG_LOG2];
      end
    end
  end

  assign o_filt  = r_filt;
  assign o_valid = r_valid;

endmodule

// File: rtl/delta_demod.sv
// Adaptive delta demodulator: run tracking, step adaptation, integrator.
// Reconstructed samples feed a moving-average smoother.
module delta_demod
  import delta_pkg::*;
#(
  parameter int WIDTH    = WIDTH_D,
  parameter int STEP_MIN = STEP_MIN_D,
  parameter int STEP_MAX = STEP_MAX_D,
  parameter int RUN_LEN  = RUN_LEN_D,
  parameter int AVG_LOG2 = AVG_LOG2_D
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              adaptive_en,
  output logic [WIDTH-1:0]  recon_out,
  output logic [STEP_W-1:0] step_out,
  output logic [WIDTH-1:0]  filt_out,
  output logic              out_valid,
  output logic              slope_ovl
);

  localparam int          RW   = $clog2(RUN_LEN + 1);
  localparam int unsigned MAXV = (1 << WIDTH) - 1;

  logic [WIDTH-1:0]  r_acc;
  logic [STEP_W-1:0] r_step;
  logic [RW-1:0]     r_run;
  logic              r_last;
  logic              r_vld;

  logic [RW-1:0]     w_run_nxt;
  logic [STEP_W-1:0] w_step_nxt;
  logic [WIDTH-1:0]  w_acc_nxt;

  always_comb begin
    w_run_nxt = RW'(1);
    if (bit_in == r_last) begin
      w_run_nxt = (r_run == RW'(RUN_LEN)) ? r_run : r_run + 1'b1;
    end
  end

  assign w_step_nxt = STEP_W'(step_adapt(
    32'(r_step), 32'(w_run_nxt), RUN_LEN,
    bit_in, r_last, adaptive_en,
    STEP_MIN, STEP_MAX));

  // The new step is applied to this same sample, not the next one.
  assign w_acc_nxt = bit_in
    ? WIDTH'(sat_add(32'(r_acc), 32'(w_step_nxt), MAXV))
    : WIDTH'(sat_sub(32'(r_acc), 32'(w_step_nxt)));

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_step <= STEP_W'(STEP_MIN);
      r_run  <= '0;
      r_last <= 1'b0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= bit_valid;
      if (bit_valid) begin
        r_acc  <= w_acc_nxt;
        r_step <= w_step_nxt;
        r_run  <= w_run_nxt;
        r_last <= bit_in;
      end
    end
  end

  moving_avg #(
    .WIDTH    (WIDTH),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .i_clk   (clk_in),
    .i_rst_n (rst_n),
    .i_valid (r_vld),
    .i_data  (r_acc),
    .o_filt  (filt_out),
    .o_valid (out_valid)
  );

  assign recon_out = r_acc;
  assign step_out  = r_step;
  assign slope_ovl = (r_step == STEP_W'(STEP_MAX));

endmodule

// File: tb/tb_delta_demod.sv
// Directed bench for delta_demod with hand-computed expected values.
// Inputs change 1 time unit after the rising edge; outputs sampled there too.
module tb_delta_demod;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       adaptive_en;
  logic [7:0] recon_out;
  logic [4:0] step_out;
  logic [7:0] filt_out;
  logic       out_valid;
  logic       slope_ovl;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses;

  int fexp  [10] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 8};
  int a_bit [8]  = '{1, 1, 1, 1, 1, 1, 1, 0};
  int a_stp [8]  = '{1, 1, 2, 4, 8, 16, 16, 8};
  int a_rec [8]  = '{1, 2, 4, 8, 16, 32, 48, 40};
  int a_ovl [8]  = '{0, 0, 0, 0, 0, 1, 1, 0};

  delta_demod dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .adaptive_en (adaptive_en),
    .recon_out   (recon_out),
    .step_out    (step_out),
    .filt_out    (filt_out),
    .out_valid   (out_valid),
    .slope_ovl   (slope_ovl)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    tick();
    rst_n     = 1'b1;
    bit_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_recon"}, int'(recon_out), 0);
    chk({tag, "_step"}, int'(step_out), 1);
    chk({tag, "_filt"}, int'(filt_out), 0);
    chk({tag, "_oval"}, int'(out_valid), 0);
    chk({tag, "_ovl"}, int'(slope_ovl), 0);
  endtask

  task automatic send(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    bit_in      = 1'b0;
    bit_valid   = 1'b0;
    adaptive_en = 1'b0;
    #1;

    do_reset();
    chk_reset("reset");

    // non-adaptive ramp
    for (int i = 1; i <= 10; i++) begin
      send(1'b1);
      chk("na_recon", int'(recon_out), i);
      chk("na_step", int'(step_out), 1);
      if (i > 1) begin
        chk("na_oval", int'(out_valid), 1);
        chk("na_filt", int'(filt_out), fexp[i-2]);
      end
    end
    bit_valid = 1'b0;
    tick();
    chk("na_filt_final", int'(filt_out), 8);
    chk("na_oval_final", int'(out_valid), 1);
    tick();
    chk("na_oval_drop", int'(out_valid), 0);
    chk("na_recon_hold", int'(recon_out), 10);
    chk("na_filt_hold", int'(filt_out), 8);

    // adaptive step growth and shrink
    do_reset();
    adaptive_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(a_bit[i][0]);
      chk("ad_step", int'(step_out), a_stp[i]);
      chk("ad_recon", int'(recon_out), a_rec[i]);
      chk("ad_ovl", int'(slope_ovl), a_ovl[i]);
    end

    // saturation: 12 unit steps, then adapt up to 250 at step 16
    do_reset();
    adaptive_en = 1'b0;
    for (int i = 0; i < 12; i++) send(1'b1);
    chk("sat_pre", int'(recon_out), 12);
    adaptive_en = 1'b1;
    for (int i = 0; i < 17; i++) send(1'b1);
    chk("sat_250", int'(recon_out), 250);
    chk("sat_step16", int'(step_out), 16);
    chk("sat_ovl", int'(slope_ovl), 1);
    send(1'b1);
    chk("sat_255", int'(recon_out), 255);
    chk("sat_step_cap", int'(step_out), 16);
    send(1'b1);
    chk("sat_255_hold", int'(recon_out), 255);
    send(1'b0);
    chk("dn_first", int'(recon_out), 247);
    chk("dn_step8", int'(step_out), 8);
    for (int i = 0; i < 40; i++) begin
      send(1'b0);
      chk("dn_step_hi", int'(step_out <= 5'd16), 1);
      chk("dn_step_lo", int'(step_out >= 5'd1), 1);
    end
    chk("dn_floor", int'(recon_out), 0);
    chk("dn_step_end", int'(step_out), 16);

    // gaps in bit_valid: 1, 0, 0, 1
    do_reset();
    adaptive_en = 1'b0;
    pulses = 0;
    send(1'b1);
    chk("gap_r1", int'(recon_out), 1);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    tick();
    pulses += int'(out_valid);
    chk("gap_hold1", int'(recon_out), 1);
    chk("gap_filt1", int'(filt_out), 0);
    tick();
    pulses += int'(out_valid);
    chk("gap_hold2", int'(recon_out), 1);
    chk("gap_step_hold", int'(step_out), 1);
    send(1'b1);
    pulses += int'(out_valid);
    chk("gap_r2", int'(recon_out), 2);
    bit_valid = 1'b0;
    tick();
    pulses += int'(out_valid);
    tick();
    pulses += int'(out_valid);
    tick();
    pulses += int'(out_valid);
    chk("gap_pulses", pulses, 2);
    chk("gap_final", int'(recon_out), 2);

    // reset in the middle of a ones run
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b1);
    chk("mid_pre", int'(recon_out), 4);
    rst_n     = 1'b0;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    chk_reset("mid_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b1);
    chk("mid_recon", int'(recon_out), 4);
    bit_valid = 1'b0;
    tick();
    chk("mid_filt", int'(filt_out), 2);
    chk("mid_oval", int'(out_valid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
